paddle_ctrl: RTL
================

Name: paddle_ctrl

Overview:
- Upstream of the puck-state FSM; one instance per side (left, right).
- Converts raw board buttons (up, mid, down) into a debounced, rate-limited, clamped paddle position (px, py).
- Also produces one-hot motion flags; these drive the FSM's Lx/Ly/Lup/Lmid/Ldown inputs (or the R* equivalents).
- Up decreases Y (screen coordinates). Mid recentres the paddle.

Parameters:
- X_POS, 160: fixed paddle X coordinate (pixels).
- Y_INIT, 240: reset Y position, also the recentre target.
- Y_MIN, 0: top playfield edge.
- Y_MAX, 479: bottom playfield edge.
- RADIUS, 13: paddle radius; sets the clamp margin.
- STEP, 2: pixels moved per step tick.
- STEP_DIV, 250000: clock cycles per step tick.
- DB_CYCLES, 500000: consecutive stable samples required to accept a button level.
- ACCEL_TICKS, 16: held-direction ticks before acceleration (optional feature only).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- btn_up  in  1  raw up button, asynchronous to clk
- btn_mid  in  1  raw recentre button, asynchronous to clk
- btn_down  in  1  raw down button, asynchronous to clk
- px  out  11  paddle X, always X_POS
- py  out  11  paddle Y, registered
- p_up  out  1  high while in MOVE_UP
- p_mid  out  1  high while in RECENTER
- p_down  out  1  high while in MOVE_DOWN

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-low; asserting it clears all state immediately, mid-move included.
- Reset values: py=Y_INIT, px=X_POS, p_up=p_mid=p_down=0, state=IDLE, prescaler=0, debounced levels=0, debounce counters=0.
- Synchroniser: each button passes through a 2-flop synchroniser.
- Debounce: the debounced level changes only after DB_CYCLES consecutive cycles of a new synchronised value. Any mismatch restarts the count.
- Prescaler: free-running, counts 0..STEP_DIV-1 from reset. step_tick is high for exactly one cycle, when count==STEP_DIV-1.
- State machine (enum IDLE, MOVE_UP, MOVE_DOWN, RECENTER), evaluated every cycle on debounced levels (u, m, d):
  - IDLE: m -> RECENTER; else u&!d -> MOVE_UP; else d&!u -> MOVE_DOWN; else stay IDLE.
  - MOVE_UP / MOVE_DOWN: m -> RECENTER; u&d or neither held -> IDLE; the opposite button alone -> the opposite move state.
  - RECENTER: runs to completion even if m is released. u and d are ignored. Exit to IDLE only on the tick that lands on Y_INIT.
- Flag timing: state and flags update on the cycle after a debounced level changes. Flags are the registered one-hot decode of state.
- py update: only on step_tick cycles. Arithmetic uses a 12-bit signed intermediate so there is no wrap-around.
  - MOVE_UP: py = max(py-STEP, Y_MIN+RADIUS).
  - MOVE_DOWN: py = min(py+STEP, Y_MAX-RADIUS).
  - RECENTER: if |py-Y_INIT| <= STEP, py=Y_INIT and state goes to IDLE on that same edge; otherwise py moves STEP toward Y_INIT.
- At a clamp: state stays in MOVE_UP/MOVE_DOWN, the flag stays high, py holds.
- Simultaneous events: a state change and step_tick on the same cycle apply the move of the pre-transition state.
- Worst-case latency, raw press to first py change: 2 + DB_CYCLES + 1 + STEP_DIV cycles.

Optional Feature:
- Macro: PADDLE_ACCEL_EN.
- When defined: a held-tick counter increments on each step_tick spent in MOVE_UP/MOVE_DOWN and saturates. Once it reaches ACCEL_TICKS, the step becomes 2*STEP (clamping unchanged). The counter clears on any state change or reset.
- When undefined: the step is always STEP, and the counter is not synthesised.

Decomposition:
- Package paddle_pkg:
  - COORD_W=11.
  - paddle_state_t enum (IDLE, MOVE_UP, MOVE_DOWN, RECENTER).
  - One-hot flag encoding constants.
- Sub-module btn_debounce (synchroniser plus stable counter, parameter DB_CYCLES), instantiated three times.

Test Plan (STEP_DIV=4, DB_CYCLES=3, STEP=2, RADIUS=13, Y_INIT=240; ACCEL off unless stated):
- Assert reset low -> py=240, px=160, all flags 0. Release reset, no buttons for 100 cycles -> py stays 240.
- Hold btn_up for 10 step ticks after debounce -> p_up=1, py=220. Release -> p_up=0 within 2+3+1 cycles, py holds 220.
- Hold btn_up until clamped -> py stops at 13 and p_up stays 1. Then hold btn_down 5 ticks -> py=23, p_down=1.
- Pulse btn_down for 2 cycles (glitch shorter than DB_CYCLES) -> flags remain 0, py unchanged.
- From py=13, pulse btn_mid (debounced, then released) -> p_mid=1; py steps 15, 17, …, 239, then 240; then p_mid=0 and state IDLE. Pressing btn_up during this has no effect.
- Hold btn_up and btn_down together -> py constant, flags 0. Pull reset low mid-move at py=200 -> py=240 asynchronously. With PADDLE_ACCEL_EN: after 16 held ticks, per-tick delta becomes 4.

Source files
------------

// File: rtl/paddle_pkg.sv
// -----------------------------------------------------------------------------
// paddle_pkg
// Shared types and constants for the paddle controller slice.
//   COORD_W        : width of screen coordinates (px, py)
//   paddle_state_t : paddle motion state
//   FLAG_*         : one-hot motion flag encodings {up, mid, down}
//   flags_of()     : state -> one-hot flag decode
// -----------------------------------------------------------------------------
package paddle_pkg;

  localparam int COORD_W = 11;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    RECENTER  = 2'd3
  } paddle_state_t;

  // Flag vector layout is {up, mid, down}.
  localparam int FLAG_UP_IDX   = 2;
  localparam int FLAG_MID_IDX  = 1;
  localparam int FLAG_DOWN_IDX = 0;

  localparam logic [2:0] FLAG_NONE = 3'b000;
  localparam logic [2:0] FLAG_UP   = 3'b100;
  localparam logic [2:0] FLAG_MID  = 3'b010;
  localparam logic [2:0] FLAG_DOWN = 3'b001;

  function automatic logic [2:0] flags_of(input paddle_state_t s);
    case (s)
      MOVE_UP:   return FLAG_UP;
      MOVE_DOWN: return FLAG_DOWN;
      RECENTER:  return FLAG_MID;
      default:   return FLAG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/paddle_ctrl_if.sv
// -----------------------------------------------------------------------------
// paddle_ctrl_if
// Bundles the raw board buttons and the paddle outputs of one paddle side.
//   btn_up, btn_mid, btn_down : raw buttons, asynchronous to clk
//   px, py                    : paddle position (COORD_W bits each)
//   p_up, p_mid, p_down       : one-hot motion flags toward the puck FSM
// Modports:
//   master : board/consumer side (drives buttons, reads position and flags)
//   slave  : paddle_ctrl side (reads buttons, drives position and flags)
// -----------------------------------------------------------------------------
interface paddle_ctrl_if;
  import paddle_pkg::*;

  logic               btn_up;
  logic               btn_mid;
  logic               btn_down;
  logic [COORD_W-1:0] px;
  logic [COORD_W-1:0] py;
  logic               p_up;
  logic               p_mid;
  logic               p_down;

  modport master (
    output btn_up, btn_mid, btn_down,
    input  px, py, p_up, p_mid, p_down
  );

  modport slave (
    input  btn_up, btn_mid, btn_down,
    output px, py, p_up, p_mid, p_down
  );

endinterface

// File: rtl/paddle_ctrl_btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Two-flop synchroniser followed by a stable-level counter. The debounced
// level only takes a new value after DB_CYCLES consecutive synchronised
// samples that differ from it; any sample equal to the current level
// restarts the count.
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-low reset (level and counter clear to 0)
//   raw   : raw button input, asynchronous to clk
//   level : debounced button level
// -----------------------------------------------------------------------------
module btn_debounce #(
  parameter int DB_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      cnt     <= '0;
      level   <= 1'b0;
    end else begin
      // p0 -> p1: metastability settling
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      // p1 -> level: stable-sample count
      if (sync_p1 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync_p1;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/paddle_ctrl.sv
// -----------------------------------------------------------------------------
// paddle_ctrl
// Turns raw up/mid/down buttons into a debounced, rate-limited, clamped
// paddle position plus one-hot motion flags for the puck-state FSM.
// Up decreases Y (screen coordinates); mid recentres the paddle on Y_INIT.
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-low reset
//   bus   : paddle_ctrl_if.slave
//             btn_up/btn_mid/btn_down in  : raw buttons
//             px out : fixed X_POS
//             py out : registered Y position
//             p_up/p_mid/p_down out : registered one-hot state flags
// Build option:
//   PADDLE_ACCEL_EN : when defined, the step doubles once a move direction
//                     has been held for ACCEL_TICKS step ticks.
// -----------------------------------------------------------------------------
module paddle_ctrl
  import paddle_pkg::*;
#(
  parameter int X_POS       = 160,
  parameter int Y_INIT      = 240,
  parameter int Y_MIN       = 0,
  parameter int Y_MAX       = 479,
  parameter int RADIUS      = 13,
  parameter int STEP        = 2,
  parameter int STEP_DIV    = 250000,
  parameter int DB_CYCLES   = 500000,
  parameter int ACCEL_TICKS = 16
) (
  input  logic         clk,
  input  logic         reset,
  paddle_ctrl_if.slave bus
);

  // One extra bit plus sign keeps py +/- step from wrapping near the edges.
  localparam int POS_W = COORD_W + 1;
  typedef logic signed [POS_W-1:0] pos_t;

  localparam pos_t Y_LO   = pos_t'(Y_MIN + RADIUS);
  localparam pos_t Y_HI   = pos_t'(Y_MAX - RADIUS);
  localparam pos_t Y_CTR  = pos_t'(Y_INIT);
  localparam pos_t STEP_S = pos_t'(STEP);

  localparam int PRE_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(STEP_DIV - 1);

  function automatic pos_t sat_up(input pos_t v);
    return (v < Y_LO) ? Y_LO : v;
  endfunction

  function automatic pos_t sat_down(input pos_t v);
    return (v > Y_HI) ? Y_HI : v;
  endfunction

  function automatic logic near_centre(input pos_t v, input pos_t s);
    pos_t diff;
    diff = v - Y_CTR;
    return (diff <= s) && (diff >= -s);
  endfunction

  function automatic pos_t toward_centre(input pos_t v, input pos_t s);
    if (near_centre(v, s)) return Y_CTR;
    else if (v > Y_CTR)    return v - s;
    else                   return v + s;
  endfunction

  logic          up_db;
  logic          mid_db;
  logic          down_db;
  logic [PRE_W-1:0] pre_cnt;
  logic          step_tick;
  paddle_state_t state;
  paddle_state_t state_nx;
  logic [2:0]    flags_q;
  pos_t          py_q;
  pos_t          py_calc;
  pos_t          step_amt;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_up (
    .clk   (clk),
    .reset (reset),
    .raw   (bus.btn_up),
    .level (up_db)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_mid (
    .clk   (clk),
    .reset (reset),
    .raw   (bus.btn_mid),
    .level (mid_db)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_down (
    .clk   (clk),
    .reset (reset),
    .raw   (bus.btn_down),
    .level (down_db)
  );

  // Free-running step prescaler.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_cnt <= '0;
    end else if (pre_cnt == PRE_LAST) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  assign step_tick = (pre_cnt == PRE_LAST);

`ifdef PADDLE_ACCEL_EN
  localparam int HELD_W = $clog2(ACCEL_TICKS + 1);
  localparam logic [HELD_W-1:0] HELD_MAX = HELD_W'(ACCEL_TICKS);

  logic [HELD_W-1:0] held_q;
  logic              moving;

  assign moving = (state == MOVE_UP) || (state == MOVE_DOWN);

  // Clear wins over count so a direction change always starts slow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      held_q <= '0;
    end else if (state_nx != state) begin
      held_q <= '0;
    end else if (step_tick && moving && (held_q != HELD_MAX)) begin
      held_q <= held_q + 1'b1;
    end
  end

  assign step_amt = (held_q == HELD_MAX) ? pos_t'(2 * STEP) : STEP_S;
`else
  assign step_amt = STEP_S;
`endif

  // Next state from debounced levels; RECENTER ignores buttons until it lands.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (mid_db)                 state_nx = RECENTER;
        else if (up_db && !down_db) state_nx = MOVE_UP;
        else if (down_db && !up_db) state_nx = MOVE_DOWN;
      end
      MOVE_UP: begin
        if (mid_db)                 state_nx = RECENTER;
        else if (up_db == down_db)  state_nx = IDLE;
        else if (down_db)           state_nx = MOVE_DOWN;
      end
      MOVE_DOWN: begin
        if (mid_db)                 state_nx = RECENTER;
        else if (up_db == down_db)  state_nx = IDLE;
        else if (up_db)             state_nx = MOVE_UP;
      end
      RECENTER: begin
        if (step_tick && near_centre(py_q, STEP_S)) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Position move is always that of the current (pre-transition) state.
  always_comb begin
    py_calc = py_q;
    if (step_tick) begin
      case (state)
        MOVE_UP:   py_calc = sat_up(py_q - step_amt);
        MOVE_DOWN: py_calc = sat_down(py_q + step_amt);
        RECENTER:  py_calc = toward_centre(py_q, STEP_S);
        default:   py_calc = py_q;
      endcase
    end
  end

  // State register with flags decoded from the same next state, so the
  // flags are always the one-hot image of the registered state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      flags_q <= FLAG_NONE;
      py_q    <= Y_CTR;
    end else begin
      state   <= state_nx;
      flags_q <= flags_of(state_nx);
      py_q    <= py_calc;
    end
  end

  assign bus.px     = COORD_W'(X_POS);
  assign bus.py     = py_q[COORD_W-1:0];
  assign bus.p_up   = flags_q[FLAG_UP_IDX];
  assign bus.p_mid  = flags_q[FLAG_MID_IDX];
  assign bus.p_down = flags_q[FLAG_DOWN_IDX];

endmodule
